// File: rtl/simd_pkg.sv
// Shared definitions for the SIMD reduction path: sequencer states and the
// summation-tree latency helper used by both the tree and its controller.
package simd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } red_state_t;

  // One adder stage per tree level.
  function automatic int tree_latency(input int pe);
    return $clog2(pe);
  endfunction

endpackage

// File: rtl/reduction_ctrl_if.sv
// Signal bundle between the reduction sequencer and its surroundings
// (start/count, PE feed handshake, tree result, scalar result port, debug state).
interface reduction_ctrl_if #(
  parameter int DATA_LEN = 32,
  parameter int CNT_W    = 16
);
  import simd_pkg::*;

  // Handshakes: a transfer happens on a rising clk edge where valid and ready
  // are both high; valid holds its payload stable until that edge, and ready
  // never depends on valid.
  logic                start_i;
  logic [CNT_W-1:0]    num_chunks_i;
  logic                pe_valid_i;
  logic                pe_ready_o;
  logic [DATA_LEN-1:0] tree_sum_i;
  logic [DATA_LEN-1:0] res_data_o;
  logic                res_valid_o;
  logic                res_ready_i;
  logic                busy_o;
  red_state_t          state;

  modport master (
    output start_i, num_chunks_i, pe_valid_i, tree_sum_i, res_ready_i,
    input  pe_ready_o, res_data_o, res_valid_o, busy_o, state
  );

  modport slave (
    input  start_i, num_chunks_i, pe_valid_i, tree_sum_i, res_ready_i,
    output pe_ready_o, res_data_o, res_valid_o, busy_o, state
  );

endinterface

// File: rtl/reduction_ctrl_valid_pipe.sv
// DEPTH-stage single-bit shift register that marks which tree outputs carry
// an accepted chunk.
module valid_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic shift_in,
  output logic shift_out
);

  logic [DEPTH-1:0] stages;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) stages <= '0;
        else       stages <= shift_in;
      end
    end else begin : g_multi
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) stages <= '0;
        else       stages <= {stages[DEPTH-2:0], shift_in};
      end
    end
  endgenerate

  assign shift_out = stages[DEPTH-1];

endmodule

// File: rtl/reduction_ctrl.sv
// Sequencer for the pipelined summation tree: admits N chunks, tracks them
// through the tree latency, accumulates the results and returns one scalar.
module reduction_ctrl
  import simd_pkg::*;
#(
  parameter int PE_ELEMENTS = 4,
  parameter int DATA_LEN    = 32,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rstn,
  reduction_ctrl_if.slave  bus
);

  localparam int               TREE_LAT = tree_latency(PE_ELEMENTS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  red_state_t          state_q, state_d;
  logic [CNT_W-1:0]    n_q;
  logic [CNT_W-1:0]    accepted_q;
  logic [CNT_W-1:0]    completed_q;
  logic [DATA_LEN-1:0] acc_q;

  logic pe_ready;
  logic accept;
  logic tree_valid;
  logic complete;
  logic last_accept;
  logic last_complete;
  logic start_take;

  always_comb begin
    pe_ready      = (state_q == FEED) && (accepted_q < n_q);
    accept        = bus.pe_valid_i && pe_ready;
    complete      = tree_valid && ((state_q == FEED) || (state_q == DRAIN));
    last_accept   = accept && ((accepted_q + CNT_ONE) == n_q);
    last_complete = complete && ((completed_q + CNT_ONE) == n_q);
    start_take    = (state_q == IDLE) && bus.start_i;
  end

  valid_pipe #(.DEPTH(TREE_LAT)) u_valid_pipe (
    .clk       (clk),
    .rstn      (rstn),
    .shift_in  (accept),
    .shift_out (tree_valid)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Completion outranks the last accept so the result port is never skipped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start_i) state_d = (bus.num_chunks_i == '0) ? DONE : FEED;
      end
      FEED: begin
        if (last_complete)    state_d = DONE;
        else if (last_accept) state_d = DRAIN;
      end
      DRAIN: begin
        if (last_complete) state_d = DONE;
      end
      DONE: begin
        if (bus.res_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      n_q         <= '0;
      accepted_q  <= '0;
      completed_q <= '0;
      acc_q       <= '0;
    end else if (start_take) begin
      n_q         <= bus.num_chunks_i;
      accepted_q  <= '0;
      completed_q <= '0;
      acc_q       <= '0;
    end else begin
      if (accept) accepted_q <= accepted_q + CNT_ONE;
      if (complete) begin
        completed_q <= completed_q + CNT_ONE;
        acc_q       <= acc_q + bus.tree_sum_i;
      end
    end
  end

  assign bus.pe_ready_o  = pe_ready;
  assign bus.res_valid_o = (state_q == DONE);
  assign bus.res_data_o  = (state_q == DONE) ? acc_q : '0;
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.state       = state_q;

endmodule

// File: doc/reduction_ctrl.md
# reduction_ctrl

Sequencer for the pipelined summation tree in the SIMD processor's reduction path. A vector reduction spans `num_chunks_i` PE-width chunks. The block:
- admits one chunk per cycle into the tree;
- tracks in-flight chunks through the tree's fixed pipeline latency;
- accumulates each tree result into a running sum;
- presents the final scalar on a valid/ready result port.

The tree itself is instantiated alongside this block, not inside it.

## Interface
- `PE_ELEMENTS`, 4: number of PEs feeding the tree; power of two, ≥2.
- `DATA_LEN`, 32: data width of the tree output and accumulator.
- `CNT_W`, 16: width of the chunk count.
- `TREE_LAT`, localparam = `$clog2(PE_ELEMENTS)`: cycles from tree input to valid `sum_out`.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock.
- `rstn` in 1: async active-low reset.
- `start_i` in 1: start pulse; sampled only in IDLE.
- `num_chunks_i` in CNT_W: chunk count N; captured with `start_i`.
- `pe_valid_i` in 1: PE outputs for one chunk are on the tree inputs this cycle.
- `pe_ready_o` out 1: block accepts a chunk this cycle.
- `tree_sum_i` in DATA_LEN: tree `sum_out`.
- `res_data_o` out DATA_LEN: reduction result.
- `res_valid_o` out 1: result valid.
- `res_ready_i` in 1: consumer accepts result.
- `busy_o` out 1: high in any state other than IDLE.

## Operation
- **States:** IDLE, FEED, DRAIN, DONE.
- **IDLE:**
  - `start_i`=1 with N>0 → FEED. The block captures N and clears the accumulator and both counters.
  - `start_i`=1 with N=0 → DONE, with accumulator = 0.
- **Accept:** a chunk is accepted when `pe_valid_i & pe_ready_o`.
  - `pe_ready_o` = (state==FEED) and (accepted count < N).
  - Each accept pushes a 1 into a TREE_LAT-deep valid shift register. A non-accept pushes a 0.
- **Tree result:** when the shift register output is 1, `tree_sum_i` is added into the accumulator and the completed count increments. This happens in FEED or DRAIN.
- **FEED → DRAIN:** on the cycle the accepted count reaches N.
- **DRAIN → DONE:** on the cycle the completed count reaches N, i.e. the edge that adds the last result.
  - If the last accept and last completion would coincide, DONE takes priority. This cannot occur with TREE_LAT ≥ 1.
- **DONE:**
  - `res_valid_o`=1 and `res_data_o` = accumulator.
  - Both are held stable until `res_ready_i`=1, which returns the block to IDLE.
- **Arithmetic:** two's-complement add, modulo 2^DATA_LEN. No saturation and no overflow flag.
- **Ignored `start_i`:** in FEED, DRAIN and DONE, including the DONE→IDLE handshake cycle. A new start is accepted from the first cycle in IDLE onward.
- **`pe_valid_i` while `pe_ready_o`=0:** ignored; never pushed.
- **Reset:**
  - State → IDLE; accumulator, counters and valid shift register are cleared.
  - In-flight tree results are discarded. The tree shares `rstn`.
  - Reset values: `pe_ready_o`=0, `res_valid_o`=0, `res_data_o`=0, `busy_o`=0.

## Timing
- Chunk accepted at edge t → its tree sum is valid during cycle t+TREE_LAT → accumulated at edge t+TREE_LAT.
- Last accept at edge t → `res_valid_o` high from cycle t+TREE_LAT+1, i.e. TREE_LAT+1 cycles after the last accept.
- N=0: `res_valid_o` high the cycle after `start_i`.
- Throughput: one chunk per cycle, with back-to-back accepts sustained.
- Gaps in `pe_valid_i` stall only the feed, never the drain.
- Minimum time from `res_ready_i` handshake to the next start being accepted: 1 cycle.

## Structure
- Shared package `simd_pkg` holds:
  - the `red_state_t` enum (IDLE, FEED, DRAIN, DONE);
  - the function `tree_latency(pe)` returning `$clog2(pe)`, so that summation_tree users and this block agree on latency.
- One sub-module: `valid_pipe`, a parameterised DEPTH-bit shift register with async active-low reset and a serial in/out bit.

## Test plan
- **Single chunk:** PE_ELEMENTS=4 (TREE_LAT=2), N=1, tree inputs 1,2,3,4 → `res_data_o`=10. `res_valid_o` rises 3 cycles after the accept.
- **Back-to-back:** N=3 with consecutive chunk sums 1, 2, 3 → `res_data_o`=6. `pe_ready_o` is low after the 3rd accept; `res_valid_o` rises 3 cycles after the last accept.
- **Gaps and backpressure:**
  - N=4 with `pe_valid_i` gaps of 0–2 cycles, and `res_ready_i` held low for 5 cycles → result stays stable with valid high throughout.
  - `start_i` pulsed in DONE is ignored.
  - Extra `pe_valid_i` pulses after N accepts have no effect.
- **Empty reduction:** N=0 → `res_data_o`=0 and `res_valid_o`=1 on the cycle after start; `pe_ready_o` is never high.
- **Wrap-around:** chunk sums 0xFFFFFFFF and 0x00000002 → `res_data_o`=0x00000001.
- **Reset mid-operation:** `rstn` asserted during DRAIN with 2 results in flight → all outputs 0 immediately. A subsequent N=1 run with sum 7 returns 7, with no stale accumulation.
